histo_equalizer: RTL
====================

// Module: histo_equalizer
// PURPOSE
//  Consumes the per-frame cumulative histogram (CDF) produced by the histogram block and equalises the video stream.
//  While the sensor is in vertical blanking it reads all 256 CDF bins and builds a normalised 8-bit look-up table.
//  It then remaps every incoming grey pixel through the LUT of the previous frame.
//  Sits between the histogram/CDF RAM and the display path, as the reader of the CDF RAM.
// PARAMETERS
//  CDF_W     20   width of one CDF bin (pixel count) read from the CDF RAM
//  RD_LAT    1    CDF RAM read latency in clocks (address in cycle n -> data in cycle n+RD_LAT)
// PORTS
//  iPclk        in   1      pixel clock; all logic on rising edge
//  iRst_n       in   1      asynchronous, active-low reset
//  iFval        in   1      frame valid
//  iDval        in   1      pixel valid
//  iGrey        in   8      input grey pixel
//  iCdf_Start   in   1      one-cycle pulse: CDF RAM holds a complete new frame CDF
//  oCdf_Addr    out  8      CDF RAM read address
//  iCdf_Q       in   CDF_W  CDF RAM read data
//  oGrey_Eq     out  8      equalised pixel
//  oDval        out  1      iDval delayed to align with oGrey_Eq
//  oLut_Ready   out  1      1 = active LUT built from a real CDF; 0 = identity bypass
//  oState       out  2      FSM state, for debug
// BEHAVIOUR
//  Reset (async, iRst_n=0):
//   - outputs: oGrey_Eq=0, oDval=0, oLut_Ready=0, oCdf_Addr=0
//   - FSM: state=IDLE
//   - LUT banks: contents don't-care; the bypass flag forces identity mapping.
//   - Reset mid-SCAN/BUILD discards all partial results.
//  FSM (oState encoding): IDLE=0, SCAN=1, BUILD=2, SWAP=3.
//   IDLE  -> SCAN when iCdf_Start=1 && iFval=0.
//           iCdf_Start is ignored in every other state, and while iFval=1; it is not queued.
//   SCAN  - reads addr 0..255 (address counter wraps 255 -> done).
//         - cdf_min = first nonzero bin; total = bin 255.
//         - All bins zero -> cdf_min=0, total=0.
//         - -> BUILD after bin 255 data arrives.
//   BUILD - per index i=0..255: read cdf[i].
//         - num = (cdf[i]>=cdf_min) ? (cdf[i]-cdf_min)*255 : 0 (CDF_W+8 bits);
//           den = total-cdf_min (CDF_W bits).
//         - 8-iteration restoring serial divider, quotient q = floor(num/den); q saturates at 255.
//         - den==0 -> q=i (identity); divider is skipped.
//         - q is written to the SHADOW LUT bank at address i.
//         - Budget: at most 12 clocks per entry, at most 3100 clocks total.
//         - -> SWAP after entry 255 is written.
//   SWAP  - 1 cycle: shadow becomes active bank; oLut_Ready<=1; -> IDLE.
//  Abort: iFval rising in SCAN or BUILD -> IDLE next cycle.
//   - Shadow bank is abandoned; active bank and oLut_Ready unchanged.
//   - Build is retried only on the next iCdf_Start.
//  LUT: two 256x8 banks, double-buffered.
//   - Mapping reads only the active bank; the FSM writes only the shadow bank.
//   - The active bank never changes mid-frame, because SWAP occurs only while iFval=0.
//  Pixel path: fixed latency 2 clocks regardless of FSM state.
//   - cycle n: iGrey, iDval sampled.
//   - cycle n+2: oGrey_Eq = oLut_Ready ? LUT_active[iGrey] : iGrey; oDval = iDval.
//   - When the cycle-n+2 iDval was 0, oGrey_Eq holds its last value.
//  Arithmetic: all unsigned.
//   - cdf[i]<cdf_min (non-monotonic CDF) clamps num to 0.
//   - Quotient above 255 clamps to 255.
// TESTING
//  1. Reset, no build; iGrey=0x37, iDval=1 -> oGrey_Eq=0x37, oDval=1 two cycles later; oLut_Ready=0.
//  2. CDF cdf[i]=i+1, pulse iCdf_Start with iFval=0 -> cdf_min=1, den=255.
//     lut[i]=i; oLut_Ready=1 after SWAP; SCAN+BUILD+SWAP takes at most 3400 clocks.
//  3. CDF 0 for i<100, 1000 for 100..199, 2000 for i>=200 -> cdf_min=1000, den=1000.
//     Input 50->0, 150->0, 220->255.
//  4. All bins 500 (single grey level at 0) -> den=0 -> identity LUT; iGrey=0x80 -> 0x80; oLut_Ready=1.
//  5. Test-3 LUT active, new ramp CDF; iFval rises at BUILD entry 40.
//     -> state IDLE next cycle, oLut_Ready stays 1; input 150 still -> 0.
//  6. iRst_n=0 mid-BUILD -> state=0, oLut_Ready=0, oGrey_Eq=0 immediately (async).
//     Afterwards iGrey=0x37 with iDval=1 maps to 0x37 (identity bypass).

Source files
------------

// File: rtl/histo_equalizer_if.sv
// Pixel stream and CDF RAM read port of the histogram equaliser.
interface histo_equalizer_if #(
  parameter int CDF_W = 20
);
  logic             iFval;
  logic             iDval;
  logic [7:0]       iGrey;
  logic             iCdf_Start;
  logic [7:0]       oCdf_Addr;
  logic [CDF_W-1:0] iCdf_Q;
  logic [7:0]       oGrey_Eq;
  logic             oDval;
  logic             oLut_Ready;
  logic [1:0]       oState;

  // Video source, CDF RAM and display side
  modport master (
    output iFval, iDval, iGrey, iCdf_Start, iCdf_Q,
    input  oCdf_Addr, oGrey_Eq, oDval, oLut_Ready, oState
  );

  // Equaliser side
  modport slave (
    input  iFval, iDval, iGrey, iCdf_Start, iCdf_Q,
    output oCdf_Addr, oGrey_Eq, oDval, oLut_Ready, oState
  );
endinterface

// File: rtl/histo_equalizer.sv
// Histogram equaliser: builds a normalised 8-bit LUT from the frame CDF during
// vertical blanking and remaps the grey stream through the previous frame's LUT.
//
//  state | meaning
//  IDLE  | waiting for a CDF-ready pulse while the frame is blanked
//  SCAN  | reading all 256 bins to find cdf_min (first nonzero) and total (bin 255)
//  BUILD | per entry: read bin, scale by 255, divide by total-cdf_min, write shadow LUT
//  SWAP  | shadow bank becomes active, LUT marked ready
module histo_equalizer #(
  parameter int CDF_W  = 20,
  parameter int RD_LAT = 1
) (
  input logic              iPclk,
  input logic              iRst_n,
  histo_equalizer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, BUILD = 2'd2, SWAP = 2'd3} state_t;
  typedef enum logic [1:0] {PH_WAIT = 2'd0, PH_DIV = 2'd1, PH_WR = 2'd2} phase_t;

  localparam int NUM_W = CDF_W + 8;

  state_t            state;
  phase_t            phase;
  logic [7:0]        cdf_addr;
  logic              issue_vld;
  logic [RD_LAT-1:0] rd_pipe;
  logic [7:0]        data_idx;
  logic [CDF_W-1:0]  cdf_min;
  logic [CDF_W-1:0]  total;
  logic              min_found;
  logic [CDF_W-1:0]  rem;
  logic [7:0]        num_lo;
  logic [7:0]        quot;
  logic [2:0]        iter;
  logic              fval_q;
  logic              active_sel;
  logic              lut_ready;

  logic [7:0]        grey_d1;
  logic              dval_d1;
  logic [7:0]        grey_eq;
  logic              dval_eq;

  logic [7:0]        lut_mem [0:1][0:255];

  logic              rd_hit;
  logic              fval_rise;
  logic              shadow_sel;
  logic [CDF_W-1:0]  den;
  logic [CDF_W-1:0]  cdf_diff;
  logic [NUM_W-1:0]  num;
  logic [CDF_W:0]    trial;
  logic              trial_ge;

  // Read-data alignment, abort detect and divider datapath
  always_comb begin
    rd_hit     = rd_pipe[RD_LAT-1];
    fval_rise  = bus.iFval & ~fval_q;
    shadow_sel = ~active_sel;
    den        = total - cdf_min;
    cdf_diff   = (bus.iCdf_Q >= cdf_min) ? (bus.iCdf_Q - cdf_min) : '0;
    // x*255 as x*256 - x
    num        = {cdf_diff, 8'd0} - {8'd0, cdf_diff};
    trial      = {rem, num_lo[7]};
    trial_ge   = (trial >= {1'b0, den});
  end

  // Sequencer: scan, build, swap and abort on frame start
  always_ff @(posedge iPclk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      phase      <= PH_WAIT;
      cdf_addr   <= '0;
      issue_vld  <= 1'b0;
      rd_pipe    <= '0;
      data_idx   <= '0;
      cdf_min    <= '0;
      total      <= '0;
      min_found  <= 1'b0;
      rem        <= '0;
      num_lo     <= '0;
      quot       <= '0;
      iter       <= '0;
      fval_q     <= 1'b0;
      active_sel <= 1'b0;
      lut_ready  <= 1'b0;
    end else begin
      fval_q <= bus.iFval;
      if (state == IDLE) rd_pipe <= '0;
      else               rd_pipe <= (RD_LAT)'({rd_pipe, issue_vld});

      case (state)
        IDLE: begin
          issue_vld <= 1'b0;
          if (bus.iCdf_Start && !bus.iFval) begin
            state     <= SCAN;
            cdf_addr  <= '0;
            issue_vld <= 1'b1;
            data_idx  <= '0;
            cdf_min   <= '0;
            total     <= '0;
            min_found <= 1'b0;
          end
        end
        SCAN: begin
          if (issue_vld) begin
            if (cdf_addr == 8'd255) issue_vld <= 1'b0;
            else                    cdf_addr  <= cdf_addr + 8'd1;
          end
          if (rd_hit) begin
            data_idx <= data_idx + 8'd1;
            if (!min_found && bus.iCdf_Q != '0) begin
              cdf_min   <= bus.iCdf_Q;
              min_found <= 1'b1;
            end
            if (data_idx == 8'd255) begin
              total     <= bus.iCdf_Q;
              state     <= BUILD;
              phase     <= PH_WAIT;
              cdf_addr  <= '0;
              issue_vld <= 1'b1;
            end
          end
        end
        BUILD: begin
          issue_vld <= 1'b0;
          case (phase)
            PH_WAIT: begin
              if (rd_hit) begin
                if (den == '0) begin
                  quot  <= cdf_addr;
                  phase <= PH_WR;
                end else if (num[NUM_W-1:8] >= den) begin
                  // quotient would need a ninth bit
                  quot  <= 8'hFF;
                  phase <= PH_WR;
                end else begin
                  rem    <= num[NUM_W-1:8];
                  num_lo <= num[7:0];
                  iter   <= '0;
                  phase  <= PH_DIV;
                end
              end
            end
            PH_DIV: begin
              if (trial_ge) rem <= trial[CDF_W-1:0] - den;
              else          rem <= trial[CDF_W-1:0];
              quot   <= {quot[6:0], trial_ge};
              num_lo <= {num_lo[6:0], 1'b0};
              iter   <= iter + 3'd1;
              if (iter == 3'd7) phase <= PH_WR;
            end
            PH_WR: begin
              if (cdf_addr == 8'd255) begin
                state <= SWAP;
              end else begin
                cdf_addr  <= cdf_addr + 8'd1;
                issue_vld <= 1'b1;
                phase     <= PH_WAIT;
              end
            end
            default: phase <= PH_WAIT;
          endcase
        end
        SWAP: begin
          active_sel <= ~active_sel;
          lut_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if ((state == SCAN || state == BUILD) && fval_rise) begin
        state     <= IDLE;
        issue_vld <= 1'b0;
      end
    end
  end

  // Finished LUT entries go to the shadow bank only
  always_ff @(posedge iPclk) begin
    if (state == BUILD && phase == PH_WR) lut_mem[shadow_sel][cdf_addr] <= quot;
  end

  // Two-stage pixel remap through the active bank, identity until a LUT exists
  always_ff @(posedge iPclk or negedge iRst_n) begin
    if (!iRst_n) begin
      grey_d1 <= '0;
      dval_d1 <= 1'b0;
      grey_eq <= '0;
      dval_eq <= 1'b0;
    end else begin
      grey_d1 <= bus.iGrey;
      dval_d1 <= bus.iDval;
      dval_eq <= dval_d1;
      if (dval_d1) grey_eq <= lut_ready ? lut_mem[active_sel][grey_d1] : grey_d1;
    end
  end

  assign bus.oCdf_Addr  = cdf_addr;
  assign bus.oGrey_Eq   = grey_eq;
  assign bus.oDval      = dval_eq;
  assign bus.oLut_Ready = lut_ready;
  assign bus.oState     = state;
endmodule
